// File: rtl/eight_bit_divider_if.sv
// Request/response bundle for the sequential unsigned divider.
// Latency: n/a (wires only); master drives operands and start, slave returns results.
// Backpressure: none; start is only honoured while the divider is idle.
interface eight_bit_divider_if #(
    parameter int DATA_W = 8
);
    logic                  start;
    logic [2*DATA_W-1:0]   dividend;
    logic [DATA_W-1:0]     divisor;
    logic                  busy;
    logic                  done;
    logic [2*DATA_W-1:0]   quotient;
    logic [DATA_W-1:0]     remainder;
    logic                  div_by_zero;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero
    );
endinterface

// File: rtl/eight_bit_divider.sv
// Unsigned restoring divider, 2*DATA_W-bit dividend by DATA_W-bit divisor, one quotient bit per clock.
// Latency: done pulses 2*DATA_W+1 cycles after the start edge (1 cycle for a zero divisor).
// Backpressure: start is sampled only in IDLE; requests during CALC/DONE are dropped, not queued.
module eight_bit_divider #(
    parameter int DATA_W = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    eight_bit_divider_if.slave  bus
);
    localparam int Q_W   = 2 * DATA_W;
    localparam int CNT_W = $clog2(Q_W);
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(Q_W - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_DONE
    } state_t;

    state_t              r_state;
    // Partial remainder carries one extra bit so the shifted value never overflows the compare.
    logic [DATA_W:0]     r_prem;
    // Holds the remaining dividend bits; quotient bits shift in from the bottom as they are produced.
    logic [Q_W-1:0]      r_dvd;
    logic [DATA_W-1:0]   r_dvsr;
    logic [CNT_W-1:0]    r_cnt;
    logic                r_busy;
    logic                r_done;
    logic [Q_W-1:0]      r_quot;
    logic [DATA_W-1:0]   r_rem;
    logic                r_dbz;

    logic [DATA_W:0]     w_shift;
    logic                w_ge;
    logic [DATA_W:0]     w_prem_nxt;
    logic [Q_W-1:0]      w_dvd_nxt;

    // One restoring step: bring in the next dividend bit, subtract when it fits.
    // r_prem is always below the divisor, so its top bit is zero and dropping it is safe.
    assign w_shift    = {r_prem[DATA_W-1:0], r_dvd[Q_W-1]};
    assign w_ge       = (w_shift >= {1'b0, r_dvsr});
    assign w_prem_nxt = w_ge ? (w_shift - {1'b0, r_dvsr}) : w_shift;
    assign w_dvd_nxt  = {r_dvd[Q_W-2:0], w_ge};

    // Control FSM with registered status and result outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_prem  <= '0;
            r_dvd   <= '0;
            r_dvsr  <= '0;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_quot  <= '0;
            r_rem   <= '0;
            r_dbz   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_prem <= '0;
                        r_cnt  <= '0;
                        if (bus.divisor == '0) begin
                            // Zero divisor: skip the iterations and report saturated quotient.
                            r_quot  <= '1;
                            r_rem   <= bus.dividend[DATA_W-1:0];
                            r_dbz   <= 1'b1;
                            r_state <= S_DONE;
                        end else begin
                            r_dvd   <= bus.dividend;
                            r_dvsr  <= bus.divisor;
                            r_dbz   <= 1'b0;
                            r_busy  <= 1'b1;
                            r_state <= S_CALC;
                        end
                    end
                end
                S_CALC: begin
                    r_prem <= w_prem_nxt;
                    r_dvd  <= w_dvd_nxt;
                    r_cnt  <= r_cnt + 1'b1;
                    if (r_cnt == LAST_ITER) begin
                        r_quot  <= w_dvd_nxt;
                        r_rem   <= w_prem_nxt[DATA_W-1:0];
                        r_busy  <= 1'b0;
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    // done is registered on the way out, so it is visible in the following cycle.
                    r_done  <= 1'b1;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.busy        = r_busy;
    assign bus.done        = r_done;
    assign bus.quotient    = r_quot;
    assign bus.remainder   = r_rem;
    assign bus.div_by_zero = r_dbz;

endmodule

// File: tb/tb_eight_bit_divider.sv
// Directed bench for eight_bit_divider: hand-computed quotients, latency, busy/done timing, reset abort.
// Latency: each operation is observed for 20 cycles after its start edge.
// Backpressure: exercises start re-pulses while the divider is running.
module tb_eight_bit_divider;
    logic clk;
    logic rst_n;
    int   vectors;
    int   miscompares;

    eight_bit_divider_if #(.DATA_W(8)) ifc ();

    eight_bit_divider #(.DATA_W(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Starts one operation and watches 20 cycles; optionally re-pulses start and
    // scrambles the operands while the divider is running.
    task automatic run_op(input string tag, input logic [15:0] dvd, input logic [7:0] dvs,
                          input logic [15:0] eq, input logic [7:0] er, input logic edbz,
                          input logic repulse);
        int         lat;
        int         done_cnt;
        int         first;
        int         busy_bad;
        logic [15:0] q;
        logic [7:0]  r;
        logic        z;
        lat      = edbz ? 1 : 17;
        done_cnt = 0;
        first    = 0;
        busy_bad = 0;
        q        = 'x;
        r        = 'x;
        z        = 1'bx;
        ifc.dividend = dvd;
        ifc.divisor  = dvs;
        ifc.start    = 1'b1;
        @(posedge clk);
        #1;
        ifc.start = 1'b0;
        chk({tag, ".busy_after_start"}, 32'(ifc.busy), 32'(!edbz));
        for (int k = 1; k <= 20; k++) begin
            if (repulse && (k == 5 || k == 16)) begin
                ifc.start    = 1'b1;
                ifc.dividend = 16'hA5A5;
                ifc.divisor  = 8'h03;
            end
            @(posedge clk);
            #1;
            ifc.start = 1'b0;
            if (ifc.busy !== (!edbz && k <= 15)) busy_bad++;
            if (ifc.done === 1'b1) begin
                done_cnt++;
                if (first == 0) begin
                    first = k;
                    q = ifc.quotient;
                    r = ifc.remainder;
                    z = ifc.div_by_zero;
                end
            end
        end
        chk({tag, ".done_count"}, 32'(done_cnt), 32'd1);
        chk({tag, ".latency"}, 32'(first), 32'(lat));
        chk({tag, ".busy_profile_errs"}, 32'(busy_bad), 32'd0);
        chk({tag, ".quotient"}, 32'(q), 32'(eq));
        chk({tag, ".remainder"}, 32'(r), 32'(er));
        chk({tag, ".div_by_zero"}, 32'(z), 32'(edbz));
        chk({tag, ".quotient_hold"}, 32'(ifc.quotient), 32'(eq));
        chk({tag, ".remainder_hold"}, 32'(ifc.remainder), 32'(er));
    endtask

    initial begin
        int done_seen;
        vectors      = 0;
        miscompares  = 0;
        rst_n        = 1'b0;
        ifc.start    = 1'b0;
        ifc.dividend = '0;
        ifc.divisor  = '0;
        #1;
        chk("reset.busy", 32'(ifc.busy), 32'd0);
        chk("reset.done", 32'(ifc.done), 32'd0);
        chk("reset.quotient", 32'(ifc.quotient), 32'd0);
        chk("reset.remainder", 32'(ifc.remainder), 32'd0);
        chk("reset.div_by_zero", 32'(ifc.div_by_zero), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // 3366 / 66 = 51 r 0
        run_op("case1", 16'h0D26, 8'h42, 16'h0033, 8'h00, 1'b0, 1'b0);
        // 11819 / 66 = 179 r 5
        run_op("case2a", 16'h2E2B, 8'h42, 16'h00B3, 8'h05, 1'b0, 1'b0);
        run_op("case2b", 16'hFFFF, 8'h01, 16'hFFFF, 8'h00, 1'b0, 1'b0);
        // 5 / 7 = 0 r 5 ; 65535 / 255 = 257 r 0
        run_op("case3a", 16'h0005, 8'h07, 16'h0000, 8'h05, 1'b0, 1'b0);
        run_op("case3b", 16'hFFFF, 8'hFF, 16'h0101, 8'h00, 1'b0, 1'b0);
        // Zero divisor: saturated quotient, low dividend byte as remainder
        run_op("case4", 16'h1234, 8'h00, 16'hFFFF, 8'h34, 1'b1, 1'b0);
        // Re-pulsed start and changed operands mid-run must not disturb the result
        run_op("case5", 16'h0D26, 8'h42, 16'h0033, 8'h00, 1'b0, 1'b1);

        // Reset in the middle of a calculation
        ifc.dividend = 16'h0D26;
        ifc.divisor  = 8'h42;
        ifc.start    = 1'b1;
        @(posedge clk);
        #1;
        ifc.start = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("case6.rst_busy", 32'(ifc.busy), 32'd0);
        chk("case6.rst_done", 32'(ifc.done), 32'd0);
        chk("case6.rst_quotient", 32'(ifc.quotient), 32'd0);
        chk("case6.rst_remainder", 32'(ifc.remainder), 32'd0);
        chk("case6.rst_div_by_zero", 32'(ifc.div_by_zero), 32'd0);
        done_seen = 0;
        repeat (3) begin
            @(posedge clk);
            #1;
            if (ifc.done === 1'b1) done_seen++;
        end
        rst_n = 1'b1;
        repeat (20) begin
            @(posedge clk);
            #1;
            if (ifc.done === 1'b1 || ifc.busy === 1'b1) done_seen++;
        end
        chk("case6.no_done_after_abort", 32'(done_seen), 32'd0);
        run_op("case6", 16'h2E2B, 8'h42, 16'h00B3, 8'h05, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
